// File: rtl/gate_pipe_pkg.sv
// rtl/gate_pipe_pkg.sv - op codes and field widths shared by the gate_pipe slice
package gate_pipe_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOTA = 3'd6,
    OP_BUFA = 3'd7
  } gate_op_e;

endpackage

// File: rtl/gate_pipe_if.sv
// rtl/gate_pipe_if.sv - operand/result handshake bundle for gate_pipe
// y_red exists only when GATE_REDUCE_EN is defined.
interface gate_pipe_if
  import gate_pipe_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [OP_W-1:0]  op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
`ifdef GATE_REDUCE_EN
  logic [2:0]       y_red;
`endif

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, y
`ifdef GATE_REDUCE_EN
    , input y_red
`endif
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y
`ifdef GATE_REDUCE_EN
    , output y_red
`endif
  );

endinterface

// File: rtl/gate_alu.sv
// rtl/gate_alu.sv - combinational bitwise logic unit selected by op
module gate_alu
  import gate_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  gate_op_e         op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_NOTA: y = ~a;
      OP_BUFA: y = a;
    endcase
  end

endmodule

// File: rtl/gate_pipe.sv
// rtl/gate_pipe.sv - two-stage valid/ready pipelined gate with transfer counter
// Define GATE_REDUCE_EN to add the registered y_red reduction output.
module gate_pipe
  import gate_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  gate_pipe_if.slave       bus,
  output logic [CNT_W-1:0] txn_cnt
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  gate_op_e         s1_op;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_y;
  logic [WIDTH-1:0] alu_y;
  logic             s1_load;
  logic             s2_load;

  // No skid buffer: in_ready ripples combinationally back from out_ready.
  assign s2_load     = !s2_valid || bus.out_ready;
  assign s1_load     = !s1_valid || s2_load;
  assign bus.in_ready  = s1_load;
  assign bus.out_valid = s2_valid;
  assign bus.y         = s2_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= OP_AND;
    end else if (s1_load) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_a  <= bus.a;
        s1_b  <= bus.b;
        s1_op <= gate_op_e'(bus.op);
      end
    end
  end

  gate_alu #(.WIDTH(WIDTH)) u_alu (
    .op (s1_op),
    .a  (s1_a),
    .b  (s1_b),
    .y  (alu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_y     <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_y <= alu_y;
      end
    end
  end

`ifdef GATE_REDUCE_EN
  logic [2:0] s2_red;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_red <= '0;
    end else if (s2_load && s1_valid) begin
      s2_red <= {^alu_y, |alu_y, &alu_y};
    end
  end

  assign bus.y_red = s2_red;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_cnt <= '0;
    end else if (s2_valid && bus.out_ready) begin
      txn_cnt <= txn_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gate_pipe.sv
// tb/tb_gate_pipe.sv - scoreboard bench for gate_pipe (WIDTH=4, plus a CNT_W=2 instance)
module tb_gate_pipe;
  import gate_pipe_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  gate_pipe_if #(.WIDTH(W)) bus ();
  gate_pipe_if #(.WIDTH(W)) bus2 ();
  logic [15:0] cnt;
  logic [1:0]  cnt2;

  gate_pipe #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .txn_cnt(cnt)
  );

  gate_pipe #(.WIDTH(W), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .txn_cnt(cnt2)
  );

  typedef struct {
    logic [W-1:0] y;
    logic [2:0]   red;
    bit           red_chk;
    bit           lat_chk;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   accepted = 0;
  bit   lat_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every output transfer must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%0h expected=none", bus.y);
      end else begin
        mon_e = sb.pop_front();
        check("y", 32'(bus.y), 32'(mon_e.y));
        if (mon_e.lat_chk) check("latency", cyc, mon_e.cyc + 2);
`ifdef GATE_REDUCE_EN
        if (mon_e.red_chk) check("y_red", 32'(bus.y_red), 32'(mon_e.red));
`endif
      end
    end
  end

  task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic [2:0] vop,
                      input logic [W-1:0] ey, input logic [2:0] ered, input bit rchk);
    exp_t e;
    bit   ok;
    int   n;
    ok = 1'b0;
    n  = 0;
    bus.in_valid = 1'b1;
    bus.a  = va;
    bus.b  = vb;
    bus.op = vop;
    while (!ok && n < 100) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        e.y = ey;
        e.red = ered;
        e.red_chk = rchk;
        e.lat_chk = lat_en;
        e.cyc = cyc;
        sb.push_back(e);
        accepted++;
      end else begin
        n++;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted expected=accepted");
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] tt_exp [8] = '{4'b0001, 4'b0111, 4'b1110, 4'b1000,
                             4'b0110, 4'b1001, 4'b1100, 4'b0011};
  logic [3:0] bb_a   [4] = '{4'b1100, 4'b0001, 4'b1111, 4'b0101};
  logic [3:0] bb_b   [4] = '{4'b1010, 4'b0001, 4'b0000, 4'b1111};
  logic [3:0] bb_exp [4] = '{4'b0110, 4'b0000, 4'b1111, 4'b1010};
  logic [1:0] wrap_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.op = '0; bus2.out_ready = 1'b0;

    #1 rst_n = 1'b0;
    #2;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_y", 32'(bus.y), 32'd0);
    check("rst_txn_cnt", 32'(cnt), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Truth table, back-to-back.
    bus.out_ready = 1'b1;
    lat_en = 1'b1;
    for (int i = 0; i < 8; i++) send(4'b0011, 4'b0101, 3'(i), tt_exp[i], 3'd0, 1'b0);
    wait_drain();
    check("tt_txn_cnt", 32'(cnt), 32'd8);
    lat_en = 1'b0;

    // Backpressure.
    do_reset();
    bus.out_ready = 1'b0;
    accepted = 0;
    fork
      begin
        for (int i = 1; i <= 4; i++) send(4'(i), 4'b0000, OP_OR, 4'(i), 3'd0, 1'b0);
      end
      begin
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        check("bp_accepted", accepted, 2);
        for (int k = 0; k < 3; k++) begin
          check("bp_out_valid", 32'(bus.out_valid), 32'd1);
          check("bp_y_held", 32'(bus.y), 32'd1);
          @(negedge clk);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    check("bp_txn_cnt", 32'(cnt), 32'd4);

    // Bubbles: input every other cycle.
    do_reset();
    bus.out_ready = 1'b1;
    lat_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(bb_a[i], bb_b[i], OP_XOR, bb_exp[i], 3'd0, 1'b0);
      @(negedge clk);
      check("bubble_low", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    wait_drain();
    lat_en = 1'b0;
    check("bubble_txn_cnt", 32'(cnt), 32'd4);

    // Counter wrap on the CNT_W=2 instance.
    do_reset();
    bus2.out_ready = 1'b1;
    bus2.op = OP_BUFA;
    bus2.in_valid = 1'b1;
    fork
      begin
        repeat (5) @(posedge clk);
        #1 bus2.in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        for (int k = 0; k < 5; k++) begin
          #1 check("wrap_cnt", 32'(cnt2), 32'(wrap_exp[k]));
          @(posedge clk);
        end
      end
    join
    #1;

`ifdef GATE_REDUCE_EN
    do_reset();
    check("rst_y_red", 32'(bus.y_red), 32'd0);
    bus.out_ready = 1'b1;
    send(4'b1111, 4'b0000, OP_XOR, 4'b1111, 3'b011, 1'b1);
    send(4'b1010, 4'b0000, OP_XOR, 4'b1010, 3'b010, 1'b1);
    wait_drain();
`endif

    // Mid-stream asynchronous reset with two results in flight.
    do_reset();
    bus.out_ready = 1'b1;
    send(4'b0001, 4'b0000, OP_OR, 4'b0001, 3'd0, 1'b0);
    send(4'b0010, 4'b0000, OP_OR, 4'b0010, 3'd0, 1'b0);
    send(4'b0100, 4'b0000, OP_OR, 4'b0100, 3'd0, 1'b0);
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("mid_pre_out_valid", 32'(bus.out_valid), 32'd1);
    check("mid_pre_txn_cnt", 32'(cnt), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_y", 32'(bus.y), 32'd0);
    check("mid_txn_cnt", 32'(cnt), 32'd0);
    check("mid_in_ready", 32'(bus.in_ready), 32'd1);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    check("mid_rel_in_ready", 32'(bus.in_ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("mid_no_stale", 32'(bus.out_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
